disp_scan_ctrl: RTL
===================

Name: disp_scan_ctrl

Overview:
- Upstream driver for the 8-digit multiplexed 7-segment display.
- Accepts a 32-bit hex value (8 nibbles) through a valid/ready load port and double-buffers it, so a new value appears only at a frame boundary (no tearing).
- Time-multiplexes the digits: one-hot anode select plus decoded segment pattern, advanced by a programmable prescaler.
- Feeds the board anode/segment pins directly.

Parameters:
- PRESCALE, 131072, clk cycles per digit slot; legal range ≥ 2.
- PW, 17, prescaler counter width; must satisfy 2^PW ≥ PRESCALE.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- load_valid  in  1  upstream offers load_data.
- load_data  in  32  value; nibble k drives digit k, digit 0 = rightmost.
- load_ready  out  1  pending buffer empty; a load is accepted only when load_valid && load_ready.
- anodes  out  8  one-hot digit select, active-high, bit k = digit k.
- segments  out  7  decoded pattern for the selected digit, active-high {g,f,e,d,c,b,a}.
- frame_done  out  1  one-cycle pulse when digit 7's slot ends.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: prescaler=0, idx=0, active=32'h0, pending empty, load_ready=1, anodes=8'b0000_0001, segments=7'h3F (digit "0"), frame_done=0.
- Reset mid-operation: everything returns to the values above on the next edge; any pending value is discarded.
- Prescaler: counts 0..PRESCALE-1. tick is asserted when the count equals PRESCALE-1; the count then wraps to 0.
- Digit index idx (3 bits): increments on tick, 7→0 wrap. Boundary = tick while idx==7.
- Outputs: anodes and segments are registered and reflect the new idx one cycle after the tick edge. Each digit is held exactly PRESCALE cycles.
- frame_done: registered, high for exactly one cycle, coincident with the anodes change 8'h80→8'h01.
- Load handshake:
  - Accept → pending←load_data, pending_full←1, load_ready drops the next cycle.
  - At a boundary with pending_full=1 → active←pending, pending_full←0, load_ready=1 the next cycle.
  - At a boundary with pending_full=0, active is unchanged.
  - A value accepted on the boundary cycle itself goes into pending and is transferred at the following boundary. It never bypasses to active.
  - A load_valid held while load_ready=0 is ignored. load_data need not be stable.
- Load-to-display latency: from acceptance to the first visible frame is ≤ 8·PRESCALE+1 cycles.
- Decode: the nibble active[4·idx+:4] is decoded as hex 0–F with standard patterns, e.g. 0=3F, 1=06, 8=7F, A=77, F=71.
- Prescaler width: arithmetic is unsigned. The counter must not overflow for PRESCALE = 2^PW.

Optional Feature:
- Macro DISP_LZB_EN: leading-zero blanking.
- With DISP_LZB_EN: digit k (k≥1) outputs segments=7'h00 when nibbles k..7 of active are all zero. Digit 0 is never blanked. anodes still scan all 8 positions.
- Without DISP_LZB_EN: all 8 digits are always decoded.

Decomposition:
- Shared package disp_pkg holds:
  - the 16-entry hex-to-segment constant table,
  - SEG_BLANK = 7'h00,
  - N_DIGITS = 8.
- One natural sub-module: seg_hex_decoder, a combinational 4→7 lookup from the package table. disp_scan_ctrl registers its output.

Test Plan (PRESCALE=4):
- Reset released, no loads → anodes cycle 01,02,04,…,80,01, each held 4 cycles; segments=3F throughout; frame_done pulses every 32 cycles.
- Load 32'h89ABCDEF mid-frame → load_ready=0 the next cycle; at the boundary, digit0=71(F), digit1=79(E), digit7=7F(8); load_ready=1 after the transfer.
- Two back-to-back loads, 32'h11111111 then 32'h22222222 → the second is stalled until the boundary; the display shows 1s for one full frame, then 2s.
- Load asserted exactly on the boundary cycle, 32'h00000005 → displayed only after the next boundary, not the current one.
- rst pulsed while pending_full=1 and idx=5 → next cycle anodes=01, segments=3F, load_ready=1; the pending value is never shown.
- DISP_LZB_EN defined, load 32'h00000300 → digits 0,1,2 show 3F,3F,4F; digits 3–7 show 00. Without the macro, digits 3–7 show 3F.

Source files
------------

// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared constants for the multiplexed 7-segment display driver
//
// Purpose: hex-to-segment table, blank pattern and digit count shared by
// disp_scan_ctrl and seg_hex_decoder.
// Segment bit order is {g,f,e,d,c,b,a}, active-high.
package disp_pkg;

    localparam int N_DIGITS = 8;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [6:0] HEX_SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
        7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
        7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
        7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
    };

endpackage

// File: rtl/seg_hex_decoder.sv
// rtl/seg_hex_decoder.sv - combinational hex nibble to 7-segment lookup
//
// Purpose: maps a 4-bit value to its active-high {g,f,e,d,c,b,a} pattern.
// Ports:
//   nibble    in  4  hex digit 0..F
//   segments  out 7  decoded segment pattern
module seg_hex_decoder
    import disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segments
);

    assign segments = HEX_SEG_TABLE[nibble];

endmodule

// File: rtl/disp_scan_ctrl.sv
// rtl/disp_scan_ctrl.sv - double-buffered 8-digit 7-segment scan controller
//
// Purpose: accepts a 32-bit hex value over a valid/ready port, holds it in a
// pending buffer and promotes it to the displayed value only at a frame
// boundary, then scans the eight digits with a programmable prescaler.
// Optional feature: define DISP_LZB_EN for leading-zero blanking.
// Ports:
//   clk         in  1   system clock
//   rst         in  1   synchronous reset, active-high
//   load_valid  in  1   upstream offers load_data
//   load_data   in  32  value, nibble k drives digit k (digit 0 rightmost)
//   load_ready  out 1   pending buffer empty
//   anodes      out 8   one-hot digit select, active-high
//   segments    out 7   decoded pattern for the selected digit
//   frame_done  out 1   one-cycle pulse when digit 7's slot ends
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int PRESCALE = 131072,
    parameter int PW       = 17
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_valid,
    input  logic [31:0]         load_data,
    output logic                load_ready,
    output logic [N_DIGITS-1:0] anodes,
    output logic [6:0]          segments,
    output logic                frame_done
);

    // Terminal count is compared, never exceeded, so PRESCALE = 2^PW fits.
    localparam logic [PW-1:0] CNT_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt;
    logic [2:0]    idx;
    logic [31:0]   active;
    logic [31:0]   pending;
    logic          pending_full;

    logic          tick;
    logic          boundary;
    logic          accept;
    logic [2:0]    idx_next;
    logic [31:0]   active_next;
    logic [3:0]    nib_next;
    logic [6:0]    dec_seg;
    logic [6:0]    seg_next;
    logic [7:0]    anode_next;

    assign tick       = (cnt == CNT_LAST);
    assign boundary   = tick && (idx == 3'd7);
    assign load_ready = !pending_full;
    assign accept     = load_valid && !pending_full;

    // Outputs are registered from next-state values so anodes, segments and
    // frame_done all change on the same edge as idx.
    assign idx_next    = tick ? idx + 3'd1 : idx;
    assign active_next = (boundary && pending_full) ? pending : active;
    assign nib_next    = active_next[{idx_next, 2'b00} +: 4];
    assign anode_next  = 8'h01 << idx_next;

    seg_hex_decoder u_dec (
        .nibble   (nib_next),
        .segments (dec_seg)
    );

`ifdef DISP_LZB_EN
    // Blank digit k when it and every more-significant nibble are zero.
    logic upper_zero;
    assign upper_zero = ((active_next >> {idx_next, 2'b00}) == 32'h0);
    assign seg_next   = ((idx_next != 3'd0) && upper_zero) ? SEG_BLANK : dec_seg;
`else
    assign seg_next   = dec_seg;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            idx          <= 3'd0;
            active       <= 32'h0;
            pending      <= 32'h0;
            pending_full <= 1'b0;
            anodes       <= 8'h01;
            segments     <= HEX_SEG_TABLE[0];
            frame_done   <= 1'b0;
        end else begin
            cnt        <= tick ? '0 : cnt + PW'(1);
            idx        <= idx_next;
            active     <= active_next;
            anodes     <= anode_next;
            segments   <= seg_next;
            frame_done <= boundary;
            // Transfer and accept are exclusive: accept needs an empty buffer.
            if (boundary && pending_full) begin
                pending_full <= 1'b0;
            end else if (accept) begin
                pending      <= load_data;
                pending_full <= 1'b1;
            end
        end
    end

endmodule
